// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_COUNT   = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int HDR_BYTES = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted stream bytes into little-endian 32-bit words; o_word is valid
// in the same cycle as the byte that completes it (o_word_valid).
module loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [1:0]  o_byte_idx
);

    localparam logic [1:0] LP_LAST_LANE = 2'(HDR_BYTES - 1);

    logic [23:0] r_lanes;
    logic [1:0]  r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_accept) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Newest byte enters at the top so the first byte ends up in bits [7:0].
    always_ff @(posedge clk) begin
        if (i_accept) begin
            r_lanes <= {i_byte, r_lanes[23:8]};
        end
    end

    assign o_word       = {i_byte, r_lanes};
    assign o_word_valid = i_accept && (r_idx == LP_LAST_LANE);
    assign o_byte_idx   = r_idx;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader writing sequential words into imem.
// Optional mid-frame idle timeout is compiled in with `define LOADER_TIMEOUT_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        loader_done,
    output logic        load_error,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    state_t      r_state;
    logic        r_rx_ready;
    logic        r_imem_we;
    logic [31:0] r_imem_waddr;
    logic [31:0] r_imem_wdata;
    logic        r_done;
    logic        r_error;
    logic [1:0]  r_err_code;
    logic [15:0] r_words;
    logic [15:0] r_nwords;
    logic [7:0]  r_csum;

    logic        w_accept;
    logic        w_asm_accept;
    logic        w_clr;
    logic [31:0] w_word;
    logic        w_word_valid;
    logic [1:0]  w_byte_idx;
    logic        w_timeout;

    assign w_accept     = rx_valid && r_rx_ready;
    assign w_asm_accept = w_accept && ((r_state == HDR) || (r_state == DATA));
    assign w_clr        = restart && ((r_state == DONE) || (r_state == ERROR));

    loader_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_accept     (w_asm_accept),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_byte_idx   (w_byte_idx)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [15:0] r_idle;
    logic        w_in_frame;

    // A frame is in progress once its first header byte has arrived.
    assign w_in_frame = ((r_state == HDR) && (w_byte_idx != 2'd0)) ||
                        (r_state == DATA) || (r_state == CSUM);
    assign w_timeout  = w_in_frame && !w_accept &&
                        (({16'd0, r_idle} + 32'd1) >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (!w_in_frame || w_accept) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 16'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^{w_byte_idx, TIMEOUT_CYCLES[0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= HDR;
            r_rx_ready   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_words      <= '0;
            r_nwords     <= '0;
            r_csum       <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                HDR: begin
                    if (w_timeout) begin
                        r_state    <= ERROR;
                        r_rx_ready <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                    end else if (w_accept) begin
                        r_csum <= r_csum + rx_data;
                        if (w_word_valid) begin
                            r_nwords <= w_word[15:0];
                            if ((w_word[31:16] != 16'd0) ||
                                ({16'd0, w_word[15:0]} > MAX_WORDS)) begin
                                r_state    <= ERROR;
                                r_rx_ready <= 1'b0;
                                r_error    <= 1'b1;
                                r_err_code <= ERR_COUNT;
                            end else if (w_word[15:0] == 16'd0) begin
                                r_state <= CSUM;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_timeout) begin
                        r_state    <= ERROR;
                        r_rx_ready <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                    end else if (w_accept) begin
                        r_csum <= r_csum + rx_data;
                        if (w_word_valid) begin
                            r_imem_we    <= 1'b1;
                            r_imem_waddr <= BASE_ADDR + {14'd0, r_words, 2'b00};
                            r_imem_wdata <= w_word;
                            r_words      <= r_words + 16'd1;
                            if ((r_words + 16'd1) == r_nwords) begin
                                r_state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (w_timeout) begin
                        r_state    <= ERROR;
                        r_rx_ready <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                    end else if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        if (rx_data == r_csum) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ERROR;
                            r_error    <= 1'b1;
                            r_err_code <= ERR_CSUM;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (restart) begin
                        r_state    <= HDR;
                        r_rx_ready <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= ERR_NONE;
                        r_words    <= '0;
                        r_nwords   <= '0;
                        r_csum     <= '0;
                    end
                end
                default: begin
                    r_state    <= HDR;
                    r_rx_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready     = r_rx_ready;
    assign imem_we      = r_imem_we;
    assign imem_waddr   = r_imem_waddr;
    assign imem_wdata   = r_imem_wdata;
    assign loader_done  = r_done;
    assign load_error   = r_error;
    assign err_code     = r_err_code;
    assign words_loaded = r_words;

endmodule
